// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: round-robin ALU/LSU writeback arbitration,
// a registered write stage and a busy scoreboard that issue checks for RAW/WAW hazards.
module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_rg,
  input  logic [ADDR_W-1:0] chk1_rg,
  input  logic [ADDR_W-1:0] chk2_rg,
  output logic              chk1_busy,
  output logic              chk2_busy,
  output logic              alloc_busy,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rg,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] write_rg,
  output logic [DATA_W-1:0] write_data,
  output logic              any_busy,
  output logic              err_waw
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  logic              last_r;
  logic              alu_win_s;
  logic              lsu_win_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] xfer_rg_s;
  logic [DATA_W-1:0] xfer_data_s;
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_set_s;
  logic [NREG-1:0]   busy_clr_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic              waw_s;
  logic              w_en_r;
  logic [ADDR_W-1:0] write_rg_r;
  logic [DATA_W-1:0] write_data_r;
  logic              err_waw_r;

  // Round-robin grant; readies are forced low while reset is asserted.
  always_comb begin
    alu_win_s = 1'b0;
    lsu_win_s = 1'b0;
    if (!rst) begin
      alu_win_s = 1'b0;
      lsu_win_s = 1'b0;
    end else if (alu_valid && lsu_valid) begin
      if (last_r == SRC_LSU) begin
        alu_win_s = 1'b1;
      end else begin
        lsu_win_s = 1'b1;
      end
    end else if (alu_valid) begin
      alu_win_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_win_s = 1'b1;
    end else begin
      alu_win_s = 1'b0;
      lsu_win_s = 1'b0;
    end
  end

  // Select the winning request's destination and data.
  always_comb begin
    xfer_s      = alu_win_s | lsu_win_s;
    xfer_rg_s   = alu_rg;
    xfer_data_s = alu_data;
    if (lsu_win_s) begin
      xfer_rg_s   = lsu_rg;
      xfer_data_s = lsu_data;
    end else begin
      xfer_rg_s   = alu_rg;
      xfer_data_s = alu_data;
    end
  end

  // Scoreboard next state: clear on the edge the file captures, a new alloc overrides the clear.
  always_comb begin
    busy_set_s = {NREG{1'b0}};
    busy_clr_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      busy_set_s[i] = alloc_en && (alloc_rg == ADDR_W'(i)) && (i != 0);
      busy_clr_s[i] = w_en_r && (write_rg_r == ADDR_W'(i));
    end
    busy_nxt_s    = (busy_r & ~busy_clr_s) | busy_set_s;
    busy_nxt_s[0] = 1'b0;
    waw_s = alloc_en && (alloc_rg != {ADDR_W{1'b0}}) && busy_r[alloc_rg] && !busy_clr_s[alloc_rg];
  end

  // State: scoreboard, registered write port, round-robin pointer and sticky WAW flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r       <= {NREG{1'b0}};
      w_en_r       <= 1'b0;
      write_rg_r   <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      err_waw_r    <= 1'b0;
      last_r       <= SRC_LSU;
    end else begin
      busy_r <= busy_nxt_s;
      if (waw_s) begin
        err_waw_r <= 1'b1;
      end
      // x0 transfers complete the handshake but never reach the file.
      w_en_r <= xfer_s && (xfer_rg_s != {ADDR_W{1'b0}});
      if (xfer_s) begin
        write_rg_r   <= xfer_rg_s;
        write_data_r <= xfer_data_s;
        last_r       <= lsu_win_s ? SRC_LSU : SRC_ALU;
      end
    end
  end

  assign alu_ready  = alu_win_s;
  assign lsu_ready  = lsu_win_s;
  assign chk1_busy  = busy_r[chk1_rg];
  assign chk2_busy  = busy_r[chk2_rg];
  assign alloc_busy = busy_r[alloc_rg];
  assign any_busy   = |busy_r;
  assign w_en       = w_en_r;
  assign write_rg   = write_rg_r;
  assign write_data = write_data_r;
  assign err_waw    = err_waw_r;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a behavioural scoreboard/arbiter model.
module tb_rf_wb_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_en;
  logic [AW-1:0] alloc_rg, chk1_rg, chk2_rg;
  logic          chk1_busy, chk2_busy, alloc_busy;
  logic          alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [AW-1:0] alu_rg, lsu_rg;
  logic [DW-1:0] alu_data, lsu_data;
  logic          w_en, any_busy, err_waw;
  logic [AW-1:0] write_rg;
  logic [DW-1:0] write_data;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_rg(alloc_rg), .chk1_rg(chk1_rg), .chk2_rg(chk2_rg),
    .chk1_busy(chk1_busy), .chk2_busy(chk2_busy), .alloc_busy(alloc_busy),
    .alu_valid(alu_valid), .alu_rg(alu_rg), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rg(lsu_rg), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .w_en(w_en), .write_rg(write_rg), .write_data(write_data),
    .any_busy(any_busy), .err_waw(err_waw)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a set of pending destinations, whose turn it is, and the write in flight.
  bit          m_busy [32];
  bit          m_last_lsu = 1'b1;
  bit          m_wen      = 1'b0;
  logic [4:0]  m_wrg      = 5'd0;
  logic [31:0] m_wdata    = 32'd0;
  bit          m_err      = 1'b0;
  logic [31:0] m_rf [32];
  bit          w_alu, w_lsu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void decide();
    w_alu = 1'b0;
    w_lsu = 1'b0;
    if (rst) begin
      if (alu_valid && lsu_valid) begin
        w_alu = m_last_lsu;
        w_lsu = !m_last_lsu;
      end else begin
        w_alu = alu_valid;
        w_lsu = lsu_valid;
      end
    end
  endfunction

  task automatic settle();
    bit any;
    #1;
    decide();
    any = 1'b0;
    foreach (m_busy[i]) any |= m_busy[i];
    check("alu_ready", alu_ready, w_alu);
    check("lsu_ready", lsu_ready, w_lsu);
    check("chk1_busy", chk1_busy, (chk1_rg != 5'd0) && m_busy[chk1_rg]);
    check("chk2_busy", chk2_busy, (chk2_rg != 5'd0) && m_busy[chk2_rg]);
    check("alloc_busy", alloc_busy, (alloc_rg != 5'd0) && m_busy[alloc_rg]);
    check("any_busy", any_busy, any);
    check("w_en", w_en, m_wen);
    if (m_wen) begin
      check("write_rg", write_rg, m_wrg);
      check("write_data", write_data, m_wdata);
    end
    check("err_waw", err_waw, m_err);
  endtask

  task automatic tick();
    bit was_busy;
    @(posedge clk);
    if (m_wen) m_rf[m_wrg] = m_wdata;
    if (!rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wen = 1'b0; m_wrg = 5'd0; m_wdata = 32'd0; m_err = 1'b0; m_last_lsu = 1'b1;
    end else begin
      was_busy = m_busy[alloc_rg];
      if (m_wen) m_busy[m_wrg] = 1'b0;
      if (alloc_en && alloc_rg != 5'd0) begin
        if (was_busy && !(m_wen && m_wrg == alloc_rg)) m_err = 1'b1;
        m_busy[alloc_rg] = 1'b1;
      end
      if (w_alu) begin
        m_wen = (alu_rg != 5'd0); m_wrg = alu_rg; m_wdata = alu_data; m_last_lsu = 1'b0;
      end else if (w_lsu) begin
        m_wen = (lsu_rg != 5'd0); m_wrg = lsu_rg; m_wdata = lsu_data; m_last_lsu = 1'b1;
      end else begin
        m_wen = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle();
    alloc_en = 1'b0; alloc_rg = 5'd0; chk1_rg = 5'd0; chk2_rg = 5'd0;
    alu_valid = 1'b0; alu_rg = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rg = 5'd0; lsu_data = 32'd0;
  endtask

  initial begin
    int stream [4];
    bit pa, pl;
    stream = '{1, 11, 2, 12};
    foreach (m_rf[i]) m_rf[i] = 32'd0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // 1: reset held two cycles with both requesters valid
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rg = 5'd2; lsu_rg = 5'd3;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t1_alu_ready", alu_ready, 32'd0);
      check("t1_lsu_ready", lsu_ready, 32'd0);
      tick();
    end
    idle();
    rst = 1'b1;
    settle();
    check("t1_w_en", w_en, 32'd0);
    check("t1_write_rg", write_rg, 32'd0);
    check("t1_any_busy", any_busy, 32'd0);
    check("t1_err_waw", err_waw, 32'd0);
    tick();

    // 2: single ALU writeback to x5
    alloc_en = 1'b1; alloc_rg = 5'd5; cyc();
    alloc_en = 1'b0; alloc_rg = 5'd0; chk1_rg = 5'd5;
    alu_valid = 1'b1; alu_rg = 5'd5; alu_data = 32'hDEADBEEF;
    settle();
    check("t2_alu_ready", alu_ready, 32'd1);
    check("t2_busy_before", chk1_busy, 32'd1);
    tick();
    alu_valid = 1'b0;
    settle();
    check("t2_w_en", w_en, 32'd1);
    check("t2_write_rg", write_rg, 32'd5);
    check("t2_busy_during", chk1_busy, 32'd1);
    tick();
    settle();
    check("t2_busy_after", chk1_busy, 32'd0);
    check("t2_file_x5", m_rf[5], 32'hDEADBEEF);
    tick();

    // 3: contention from a fresh reset alternates ALU, LSU
    rst = 1'b0; idle(); cyc(); rst = 1'b1;
    alu_rg = 5'd1; lsu_rg = 5'd11;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; lsu_valid = 1'b1;
      alu_data = $urandom; lsu_data = $urandom;
      settle();
      check("t3_alu_grant", alu_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_lsu_grant", lsu_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) check("t3_stream", write_rg, stream[k-1]);
      tick();
      if (k % 2 == 0) alu_rg = alu_rg + 5'd1;
      else lsu_rg = lsu_rg + 5'd1;
    end
    idle();
    settle();
    check("t3_stream_last", write_rg, stream[3]);
    tick();

    // 4: x0 writes and allocations are inert
    lsu_valid = 1'b1; lsu_rg = 5'd0; lsu_data = 32'h1234;
    settle();
    check("t4_lsu_ready", lsu_ready, 32'd1);
    tick();
    idle();
    settle();
    check("t4_w_en", w_en, 32'd0);
    tick();
    alloc_en = 1'b1; alloc_rg = 5'd0; cyc();
    alloc_en = 1'b0;
    settle();
    check("t4_chk_x0", chk1_busy, 32'd0);
    check("t4_err", err_waw, 32'd0);
    tick();

    // 5: set and clear of x7 on the same edge, then a true WAW
    alloc_en = 1'b1; alloc_rg = 5'd7; cyc();
    alloc_en = 1'b0; alu_valid = 1'b1; alu_rg = 5'd7; alu_data = 32'd77;
    cyc();
    alu_valid = 1'b0; alloc_en = 1'b1; alloc_rg = 5'd7; chk1_rg = 5'd7;
    settle();
    check("t5_w_en", w_en, 32'd1);
    tick();
    alloc_en = 1'b0;
    settle();
    check("t5_busy7", chk1_busy, 32'd1);
    check("t5_no_err", err_waw, 32'd0);
    tick();
    alloc_en = 1'b1; cyc();
    alloc_en = 1'b0;
    settle();
    check("t5_err", err_waw, 32'd1);
    tick();

    // 6: reset with x3/x9 busy and an LSU request pending
    alloc_en = 1'b1; alloc_rg = 5'd3; cyc();
    alloc_rg = 5'd9; cyc();
    alloc_en = 1'b0; lsu_valid = 1'b1; lsu_rg = 5'd4; lsu_data = 32'h44;
    rst = 1'b0;
    settle();
    check("t6_lsu_ready_rst", lsu_ready, 32'd0);
    tick();
    rst = 1'b1; lsu_valid = 1'b0;
    settle();
    check("t6_any_busy", any_busy, 32'd0);
    check("t6_w_en", w_en, 32'd0);
    check("t6_err", err_waw, 32'd0);
    tick();
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rg = 5'd6; lsu_rg = 5'd8;
    settle();
    check("t6_tie_alu", alu_ready, 32'd1);
    tick();

    // Randomized traffic with stable-until-ready requesters
    idle();
    pa = 1'b0; pl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pa && ($urandom % 3 == 0)) begin
        pa = 1'b1; alu_rg = 5'($urandom % 32); alu_data = $urandom;
      end
      if (!pl && ($urandom % 3 == 0)) begin
        pl = 1'b1; lsu_rg = 5'($urandom % 32); lsu_data = $urandom;
      end
      alu_valid = pa; lsu_valid = pl;
      alloc_en = ($urandom % 4 == 0);
      alloc_rg = 5'($urandom % 32);
      chk1_rg  = 5'($urandom % 32);
      chk2_rg  = 5'($urandom % 32);
      rst      = ($urandom % 100 != 0);
      settle();
      tick();
      if (w_alu || !rst) pa = 1'b0;
      if (w_lsu || !rst) pl = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
